// File: rtl/mmcm_drp_pkg.sv
`default_nettype none
// ============================================================================
//  mmcm_drp_pkg
//  Shared types and widths for the MMCM/PLL DRP arbiter.
//  Rev 1.0
// ============================================================================
package mmcm_drp_pkg;

    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RDY = 2'd2,
        HOLD     = 2'd3
    } drp_arb_state_t;

    typedef struct packed {
        logic                  we;
        logic [DRP_ADDR_W-1:0] addr;
        logic [DRP_DATA_W-1:0] di;
    } drp_req_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  rr_pick
//  Combinational round-robin picker: first set bit at or after rr_i, wrapping.
//  Rev 1.0
// ============================================================================
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     pend_i,
    input  logic [IDX_W-1:0] rr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from furthest to nearest so the nearest pending slot wins.
    always_comb begin
        int j;
        j       = 0;
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(rr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (pend_i[j]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmcm_drp_arbiter.sv
`default_nettype none
// ============================================================================
//  mmcm_drp_arbiter
//  Round-robin sharing of one MMCM/PLL DRP port between N_REQ masters.
//  Rev 1.0
// ============================================================================
module mmcm_drp_arbiter
    import mmcm_drp_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 64,
    parameter int IDX_W   = $clog2(N_REQ),
    parameter int TMO_W   = $clog2(TIMEOUT + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [N_REQ-1:0]             m_den_i,
    input  logic [N_REQ-1:0]             m_dwe_i,
    input  logic [N_REQ*DRP_ADDR_W-1:0]  m_daddr_i,
    input  logic [N_REQ*DRP_DATA_W-1:0]  m_di_i,
    input  logic [N_REQ-1:0]             m_lock_i,
    output logic [N_REQ-1:0]             m_drdy_o,
    output logic [DRP_DATA_W-1:0]        m_do_o,
    output logic [N_REQ-1:0]             m_err_o,
    output logic [IDX_W-1:0]             grant_o,
    output logic                         busy_o,
    output logic                         drp_den_o,
    output logic                         drp_dwe_o,
    output logic [DRP_ADDR_W-1:0]        drp_daddr_o,
    output logic [DRP_DATA_W-1:0]        drp_di_o,
    input  logic [DRP_DATA_W-1:0]        drp_do_i,
    input  logic                         drp_drdy_i
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_WAIT  = WAIT_RDY;
    localparam logic [1:0] S_HOLD  = HOLD;

    logic [1:0]            state_q, state_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      rr_q, rr_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [N_REQ-1:0]      pend_q, pend_d;
    drp_req_t              slot_q [N_REQ];

    logic                  den_q, den_d;
    logic                  dwe_q, dwe_d;
    logic [DRP_ADDR_W-1:0] daddr_q, daddr_d;
    logic [DRP_DATA_W-1:0] di_q, di_d;
    logic [N_REQ-1:0]      drdy_q, drdy_d;
    logic [N_REQ-1:0]      err_q, err_d;
    logic [DRP_DATA_W-1:0] do_q, do_d;

    logic [N_REQ-1:0]      w_accept;
    logic [N_REQ-1:0]      w_overrun;
    logic [N_REQ-1:0]      w_pend_eff;
    logic                  w_found;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      w_rr_next;
    logic                  w_done;
    drp_req_t              w_slot;

    assign w_accept   = m_den_i & ~pend_q;
    assign w_overrun  = m_den_i & pend_q;
    // A request captured this cycle is already visible to the picker.
    assign w_pend_eff = pend_q | m_den_i;
    assign w_rr_next  = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
    assign w_slot     = slot_q[grant_q];

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .pend_i  (w_pend_eff),
        .rr_i    (rr_q),
        .found_o (w_found),
        .idx_o   (w_idx)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        tmo_d   = tmo_q;
        pend_d  = pend_q | w_accept;
        den_d   = 1'b0;
        dwe_d   = dwe_q;
        daddr_d = daddr_q;
        di_d    = di_q;
        drdy_d  = '0;
        err_d   = w_overrun;
        do_d    = do_q;
        w_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    state_d = S_ISSUE;
                    grant_d = w_idx;
                end
            end
            S_ISSUE: begin
                den_d   = 1'b1;
                dwe_d   = w_slot.we;
                daddr_d = w_slot.addr;
                di_d    = w_slot.we ? w_slot.di : '0;
                tmo_d   = TMO_W'(TIMEOUT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // drdy wins over a timeout expiring in the same cycle.
                if (drp_drdy_i) begin
                    do_d            = drp_do_i;
                    drdy_d[grant_q] = 1'b1;
                    pend_d[grant_q] = 1'b0;
                    w_done          = 1'b1;
                end else if (tmo_q <= TMO_W'(1)) begin
                    err_d[grant_q]  = 1'b1;
                    pend_d[grant_q] = 1'b0;
                    w_done          = 1'b1;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
                if (w_done) begin
                    if (m_lock_i[grant_q]) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_IDLE;
                        rr_d    = w_rr_next;
                    end
                end
            end
            S_HOLD: begin
                if (w_pend_eff[grant_q]) begin
                    state_d = S_ISSUE;
                end else if (!m_lock_i[grant_q]) begin
                    state_d = S_IDLE;
                    rr_d    = w_rr_next;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < N_REQ; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_accept[i]) begin
                    slot_q[i].we   <= m_dwe_i[i];
                    slot_q[i].addr <= m_daddr_i[i*DRP_ADDR_W +: DRP_ADDR_W];
                    slot_q[i].di   <= m_di_i[i*DRP_DATA_W +: DRP_DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            tmo_q   <= '0;
            pend_q  <= '0;
            den_q   <= 1'b0;
            dwe_q   <= 1'b0;
            daddr_q <= '0;
            di_q    <= '0;
            drdy_q  <= '0;
            err_q   <= '0;
            do_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            tmo_q   <= tmo_d;
            pend_q  <= pend_d;
            den_q   <= den_d;
            dwe_q   <= dwe_d;
            daddr_q <= daddr_d;
            di_q    <= di_d;
            drdy_q  <= drdy_d;
            err_q   <= err_d;
            do_q    <= do_d;
        end
    end

    assign m_drdy_o    = drdy_q;
    assign m_err_o     = err_q;
    assign m_do_o      = do_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != S_IDLE);
    assign drp_den_o   = den_q;
    assign drp_dwe_o   = dwe_q;
    assign drp_daddr_o = daddr_q;
    assign drp_di_o    = di_q;

endmodule
`default_nettype wire

// File: tb/tb_mmcm_drp_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  tb_mmcm_drp_arbiter
//  Scoreboard bench for the DRP arbiter with a behavioural MMCM DRP model.
//  Rev 1.0
// ============================================================================
module tb_mmcm_drp_arbiter;

    localparam int N   = 2;
    localparam int TMO = 8;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [1:0]  m_den_i = '0;
    logic [1:0]  m_dwe_i = '0;
    logic [13:0] m_daddr_i = '0;
    logic [31:0] m_di_i = '0;
    logic [1:0]  m_lock_i = '0;
    logic [1:0]  m_drdy_o;
    logic [15:0] m_do_o;
    logic [1:0]  m_err_o;
    logic        grant_o;
    logic        busy_o;
    logic        drp_den_o;
    logic        drp_dwe_o;
    logic [6:0]  drp_daddr_o;
    logic [15:0] drp_di_o;
    logic [15:0] drp_do_i;
    logic        drp_drdy_i;

    always #5 clk_i = ~clk_i;

    mmcm_drp_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (TMO)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .m_den_i     (m_den_i),
        .m_dwe_i     (m_dwe_i),
        .m_daddr_i   (m_daddr_i),
        .m_di_i      (m_di_i),
        .m_lock_i    (m_lock_i),
        .m_drdy_o    (m_drdy_o),
        .m_do_o      (m_do_o),
        .m_err_o     (m_err_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .drp_den_o   (drp_den_o),
        .drp_dwe_o   (drp_dwe_o),
        .drp_daddr_o (drp_daddr_o),
        .drp_di_o    (drp_di_o),
        .drp_do_i    (drp_do_i),
        .drp_drdy_i  (drp_drdy_i)
    );

    // ---------------- MMCM DRP model: reads return 16'h122C + addr ----------
    logic [15:0] mem [128];
    int          rsp_cnt = 0;
    int          model_dly = 3;
    bit          model_en = 1'b1;
    int          den_cnt = 0;
    int          overlap_cnt = 0;
    int          wide_cnt = 0;
    bit          den_prev = 1'b0;
    logic        rsp_we;
    logic [6:0]  rsp_addr;
    logic        last_we;
    logic [6:0]  last_addr;
    logic [15:0] last_di;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'h122C + 16'(i);
    end

    always @(posedge clk_i) begin
        #1;
        drp_drdy_i = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                drp_drdy_i = 1'b1;
                drp_do_i   = rsp_we ? 16'h0000 : mem[rsp_addr];
            end
        end
        if (drp_den_o) begin
            den_cnt++;
            if (den_prev) wide_cnt++;
            if (rsp_cnt > 0) overlap_cnt++;
            last_we   = drp_dwe_o;
            last_addr = drp_daddr_o;
            last_di   = drp_di_o;
            if (drp_dwe_o) mem[drp_daddr_o] = drp_di_o;
            if (model_en) begin
                rsp_cnt  = model_dly;
                rsp_we   = drp_dwe_o;
                rsp_addr = drp_daddr_o;
            end
        end
        den_prev = drp_den_o;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          idx;
        bit          err;
        logic [15:0] data;
    } exp_t;

    exp_t        exp0_q[$];
    exp_t        exp1_q[$];
    logic [15:0] last_ok_do = 16'h0000;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic push_exp(input int idx, input bit err, input logic [15:0] data);
        exp_t e;
        e.idx = idx; e.err = err; e.data = data;
        if (idx == 0) exp0_q.push_back(e);
        else          exp1_q.push_back(e);
    endtask

    function automatic exp_t pop_exp(input int idx);
        exp_t e;
        e.idx = idx; e.err = 1'b1; e.data = 16'hDEAD;
        if (idx == 0 && exp0_q.size() > 0) e = exp0_q.pop_front();
        if (idx == 1 && exp1_q.size() > 0) e = exp1_q.pop_front();
        return e;
    endfunction

    // {m_drdy, m_err, m_do, grant} expected for a completion; m_do holds on error.
    function automatic logic [34:0] expect_vec(input exp_t e);
        logic [1:0] oh;
        oh = 2'b01 << e.idx;
        if (!e.err) last_ok_do = e.data;
        return {e.err ? 2'b00 : oh, e.err ? oh : 2'b00, last_ok_do, e.idx[0]};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse(input int idx, input logic we, input logic [6:0] addr, input logic [15:0] di);
        m_den_i[idx]          = 1'b1;
        m_dwe_i[idx]          = we;
        m_daddr_i[idx*7 +: 7] = addr;
        m_di_i[idx*16 +: 16]  = di;
        tick();
        m_den_i[idx] = 1'b0;
    endtask

    task automatic wait_den(input int max, output int cyc);
        cyc = 0;
        while (!drp_den_o && cyc < max) begin
            tick();
            cyc++;
        end
        if (!drp_den_o) cyc = -1;
    endtask

    task automatic wait_resp(input int max, output int cyc, output logic [1:0] drdy, output logic [1:0] err);
        cyc = 0; drdy = '0; err = '0;
        while (cyc < max) begin
            tick();
            cyc++;
            if ((m_drdy_o | m_err_o) != 2'b00) begin
                drdy = m_drdy_o;
                err  = m_err_o;
                return;
            end
        end
        cyc = -1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_i = 1'b1;
        tick(); tick();
        n_chk++;
        if ({m_drdy_o, m_err_o, m_do_o, grant_o, busy_o, drp_den_o, drp_dwe_o, drp_daddr_o, drp_di_o} !== 47'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {m_drdy_o, m_err_o, m_do_o, grant_o, busy_o, drp_den_o, drp_dwe_o, drp_daddr_o, drp_di_o});
        end
        reset_i = 1'b0;
        tick(); tick();
        n_chk++;
        if ({busy_o, drp_den_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: busy/den got %b required 00", {busy_o, drp_den_o});
        end
    endtask

    task automatic test_single_read();
        int cyc; logic [1:0] drdy, err; logic [34:0] ev;
        model_dly = 3;
        push_exp(0, 1'b0, 16'h1234);
        pulse(0, 1'b0, 7'h08, 16'hFFFF);
        wait_den(10, cyc);
        n_chk++;
        if (cyc !== 1) begin
            n_fail++; $display("FAIL single_den_latency: got %0d cycles after pulse, required 1", cyc);
        end
        n_chk++;
        if ({drp_dwe_o, drp_daddr_o, drp_di_o} !== {1'b0, 7'h08, 16'h0000}) begin
            n_fail++; $display("FAIL single_den_fields: got %h required %h", {drp_dwe_o, drp_daddr_o, drp_di_o}, {1'b0, 7'h08, 16'h0000});
        end
        wait_resp(20, cyc, drdy, err);
        n_chk++;
        if (cyc !== 4) begin
            n_fail++; $display("FAIL single_resp_latency: got %0d required 4", cyc);
        end
        ev = expect_vec(pop_exp(0));
        n_chk++;
        if ({drdy, err, m_do_o, grant_o} !== ev) begin
            n_fail++; $display("FAIL single_resp: got %h required %h", {drdy, err, m_do_o, grant_o}, ev);
        end
    endtask

    task automatic test_contention();
        int cyc, den0; logic [1:0] drdy, err; logic [34:0] ev;
        push_exp(1, 1'b0, 16'h122E);
        pulse(1, 1'b0, 7'h02, 16'h0000);
        wait_resp(20, cyc, drdy, err);
        ev = expect_vec(pop_exp(1));
        n_chk++;
        if ({drdy, err, m_do_o, grant_o} !== ev) begin
            n_fail++; $display("FAIL cont_warmup: got %h required %h", {drdy, err, m_do_o, grant_o}, ev);
        end
        den0 = den_cnt;
        push_exp(0, 1'b0, 16'h122D);
        push_exp(1, 1'b0, 16'h1232);
        m_daddr_i = {7'h06, 7'h01};
        m_dwe_i   = 2'b00;
        m_den_i   = 2'b11;
        tick();
        m_den_i = 2'b00;
        for (int k = 0; k < 2; k++) begin
            wait_resp(20, cyc, drdy, err);
            ev = expect_vec(pop_exp(k));
            n_chk++;
            if ({drdy, err, m_do_o, grant_o} !== ev) begin
                n_fail++; $display("FAIL cont_order%0d: got %h required %h", k, {drdy, err, m_do_o, grant_o}, ev);
            end
        end
        n_chk++;
        if ({den_cnt - den0, overlap_cnt, wide_cnt} !== {32'd2, 32'd0, 32'd0}) begin
            n_fail++; $display("FAIL cont_den_pulses: got count %0d overlap %0d wide %0d required 2 0 0", den_cnt - den0, overlap_cnt, wide_cnt);
        end
    endtask

    task automatic test_lock_rmw();
        int cyc, bad; logic [1:0] drdy, err; logic [34:0] ev;
        m_lock_i[1] = 1'b1;
        push_exp(1, 1'b0, 16'h1240);
        pulse(1, 1'b0, 7'h14, 16'h0000);
        tick();
        push_exp(0, 1'b0, 16'h122F);
        pulse(0, 1'b0, 7'h03, 16'h0000);
        wait_resp(20, cyc, drdy, err);
        ev = expect_vec(pop_exp(1));
        n_chk++;
        if ({drdy, err, m_do_o, grant_o} !== ev) begin
            n_fail++; $display("FAIL lock_read: got %h required %h", {drdy, err, m_do_o, grant_o}, ev);
        end
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if ((m_drdy_o | m_err_o) != 2'b00 || busy_o !== 1'b1 || grant_o !== 1'b1 || drp_den_o !== 1'b0) bad++;
        end
        n_chk++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL lock_hold: got %0d bad cycles required 0", bad);
        end
        push_exp(1, 1'b0, 16'h0000);
        pulse(1, 1'b1, 7'h14, 16'hA5A5);
        wait_resp(20, cyc, drdy, err);
        ev = expect_vec(pop_exp(1));
        n_chk++;
        if ({drdy, err, m_do_o, grant_o} !== ev) begin
            n_fail++; $display("FAIL lock_write: got %h required %h", {drdy, err, m_do_o, grant_o}, ev);
        end
        n_chk++;
        if ({last_we, last_addr, last_di} !== {1'b1, 7'h14, 16'hA5A5}) begin
            n_fail++; $display("FAIL lock_write_fields: got %h required %h", {last_we, last_addr, last_di}, {1'b1, 7'h14, 16'hA5A5});
        end
        push_exp(1, 1'b0, 16'hA5A5);
        pulse(1, 1'b0, 7'h14, 16'h0000);
        wait_resp(20, cyc, drdy, err);
        ev = expect_vec(pop_exp(1));
        n_chk++;
        if ({drdy, err, m_do_o, grant_o} !== ev) begin
            n_fail++; $display("FAIL lock_readback: got %h required %h", {drdy, err, m_do_o, grant_o}, ev);
        end
        m_lock_i[1] = 1'b0;
        wait_resp(20, cyc, drdy, err);
        ev = expect_vec(pop_exp(0));
        n_chk++;
        if ({drdy, err, m_do_o, grant_o} !== ev) begin
            n_fail++; $display("FAIL lock_other_after: got %h required %h", {drdy, err, m_do_o, grant_o}, ev);
        end
    endtask

    task automatic test_timeout();
        int cyc; logic [1:0] drdy, err; logic [34:0] ev;
        model_en = 1'b0;
        push_exp(0, 1'b1, 16'h0000);
        pulse(0, 1'b0, 7'h05, 16'h0000);
        wait_den(10, cyc);
        wait_resp(20, cyc, drdy, err);
        n_chk++;
        if (cyc !== TMO) begin
            n_fail++; $display("FAIL timeout_latency: got %0d required %0d", cyc, TMO);
        end
        ev = expect_vec(pop_exp(0));
        n_chk++;
        if ({drdy, err, m_do_o, grant_o} !== ev) begin
            n_fail++; $display("FAIL timeout_resp: got %h required %h", {drdy, err, m_do_o, grant_o}, ev);
        end
        n_chk++;
        if (busy_o !== 1'b0) begin
            n_fail++; $display("FAIL timeout_idle: busy got %b required 0", busy_o);
        end
        model_en = 1'b1;
        push_exp(1, 1'b0, 16'h1233);
        pulse(1, 1'b0, 7'h07, 16'h0000);
        wait_resp(20, cyc, drdy, err);
        ev = expect_vec(pop_exp(1));
        n_chk++;
        if ({drdy, err, m_do_o, grant_o} !== ev) begin
            n_fail++; $display("FAIL timeout_recover: got %h required %h", {drdy, err, m_do_o, grant_o}, ev);
        end
    endtask

    task automatic test_overrun();
        int cyc; logic [1:0] drdy, err; logic [34:0] ev;
        model_dly = 5;
        push_exp(0, 1'b0, 16'h1236);
        pulse(0, 1'b0, 7'h0A, 16'h0000);
        pulse(0, 1'b1, 7'h0B, 16'h5555);
        n_chk++;
        if ({m_err_o, drp_den_o, drp_dwe_o, drp_daddr_o} !== {2'b01, 1'b1, 1'b0, 7'h0A}) begin
            n_fail++; $display("FAIL overrun_err: got %h required %h", {m_err_o, drp_den_o, drp_dwe_o, drp_daddr_o}, {2'b01, 1'b1, 1'b0, 7'h0A});
        end
        wait_resp(20, cyc, drdy, err);
        ev = expect_vec(pop_exp(0));
        n_chk++;
        if ({drdy, err, m_do_o, grant_o} !== ev) begin
            n_fail++; $display("FAIL overrun_orig: got %h required %h", {drdy, err, m_do_o, grant_o}, ev);
        end
        repeat (4) tick();
        n_chk++;
        if ({busy_o, last_addr} !== {1'b0, 7'h0A}) begin
            n_fail++; $display("FAIL overrun_no_reissue: got %h required %h", {busy_o, last_addr}, {1'b0, 7'h0A});
        end
    endtask

    task automatic test_reset_mid();
        int cyc, bad;
        model_dly = 4;
        pulse(0, 1'b0, 7'h09, 16'h0000);
        wait_den(10, cyc);
        tick();
        reset_i = 1'b1;
        #1;
        n_chk++;
        if ({m_drdy_o, m_err_o, m_do_o, grant_o, busy_o, drp_den_o, drp_dwe_o, drp_daddr_o, drp_di_o} !== 47'd0) begin
            n_fail++;
            $display("FAIL reset_mid_zero: got %h required 0", {m_drdy_o, m_err_o, m_do_o, grant_o, busy_o, drp_den_o, drp_dwe_o, drp_daddr_o, drp_di_o});
        end
        tick();
        reset_i = 1'b0;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if ((m_drdy_o | m_err_o) != 2'b00 || busy_o !== 1'b0 || drp_den_o !== 1'b0) bad++;
        end
        n_chk++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL reset_mid_late_drdy: got %0d bad cycles required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_lock_rmw();
        test_timeout();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
